// File: rtl/roulette_pkg.sv
// Shared types and defaults for the roulette ring sequencer: state encoding,
// segment count, default timing constants and a one-hot to index helper.
package roulette_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        DECEL = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int SEG_N            = 6;
    localparam int STEP_W           = 8;
    localparam int DEF_CNT_W        = 24;
    localparam int DEF_BASE_DIV     = 1250000;
    localparam int DEF_DECEL_INC    = 625000;
    localparam int DEF_SPIN_STEPS   = 48;
    localparam int DEF_DECEL_STEPS  = 6;

    function automatic logic [2:0] seg_index(input logic [SEG_N-1:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < SEG_N; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/roulette_ctrl_if.sv
// Board-side signal bundle for roulette_ctrl: key/switch inputs, HEX0 drive,
// status outputs and a debug view of the sequencer state.
interface roulette_ctrl_if import roulette_pkg::*;;
    // start is a level whose rising edge is the command; there is no ready:
    // done is a one-cycle pulse that qualifies result, with no backpressure.
    logic             start;
    logic             dir;
    logic [SEG_N-1:0] pos;
    logic [6:0]       hex;
    logic             busy;
    logic             done;
    logic [2:0]       result;
    state_e           state;

    modport slave  (input start, dir, output pos, hex, busy, done, result, state);
    modport master (output start, dir, input pos, hex, busy, done, result, state);
endinterface

// File: rtl/roulette_ctrl_step_timer.sv
// Step interval timer: counts 0..interval-1 and pulses tick on the last count.
module step_timer import roulette_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [CNT_W-1:0] interval,
    input  logic             clear,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == interval - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/roulette_ctrl.sv
// Roulette ring sequencer: spin, decelerate, stop and report the landing index.
// Optional ROULETTE_LFSR_EN adds 0..7 pseudo-random extra deceleration steps.
module roulette_ctrl import roulette_pkg::*; #(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int BASE_DIV    = DEF_BASE_DIV,
    parameter int DECEL_INC   = DEF_DECEL_INC,
    parameter int SPIN_STEPS  = DEF_SPIN_STEPS,
    parameter int DECEL_STEPS = DEF_DECEL_STEPS
) (
    input  logic            clk,
    input  logic            nrst,
    roulette_ctrl_if.slave  io
);

    logic             s1_q, s2_q, s3_q;
    logic             start_edge;
    state_e           state_q, state_d;
    logic [SEG_N-1:0] pos_q, pos_d;
    logic [STEP_W-1:0] step_q;
    logic             busy_q, done_q, hold_entry_q;
    logic [2:0]       result_q;
    logic [2:0]       extra;
    logic [CNT_W-1:0] interval;
    logic             tick, clear, moving, spin_last, decel_last;

    assign start_edge = s2_q & ~s3_q;
    assign moving     = (state_q == SPIN) || (state_q == DECEL);
    assign spin_last  = (step_q == STEP_W'(SPIN_STEPS - 1));
    assign decel_last = (step_q == STEP_W'(DECEL_STEPS) + STEP_W'(extra) - STEP_W'(1));
    assign interval   = (state_q == DECEL)
                      ? CNT_W'(BASE_DIV) + CNT_W'(step_q) * CNT_W'(DECEL_INC)
                      : CNT_W'(BASE_DIV);

    // Start edges during DECEL are deliberately not decoded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = SPIN;
            SPIN:    if (start_edge || (tick && spin_last)) state_d = DECEL;
            DECEL:   if (tick && decel_last) state_d = HOLD;
            HOLD:    if (start_edge) state_d = SPIN;
            default: state_d = IDLE;
        endcase
    end

    assign clear = (state_d != state_q);

    always_comb begin
        pos_d = pos_q;
        if (tick && moving) pos_d = io.dir ? {pos_q[0], pos_q[5:1]} : {pos_q[4:0], pos_q[5]};
    end

    step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .interval (interval),
        .clear    (clear),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= IDLE;
            pos_q        <= 6'b000001;
            step_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hold_entry_q <= 1'b0;
            result_q     <= 3'd0;
        end else begin
            s1_q         <= io.start;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            state_q      <= state_d;
            pos_q        <= pos_d;
            if (clear)                step_q <= '0;
            else if (tick && moving)  step_q <= step_q + STEP_W'(1);
            busy_q       <= moving;
            hold_entry_q <= (state_d == HOLD) && (state_q != HOLD);
            done_q       <= hold_entry_q;
            if (hold_entry_q) result_q <= seg_index(pos_q);
        end
    end

`ifdef ROULETTE_LFSR_EN
    logic [7:0] lfsr_q;
    logic [2:0] extra_q;

    // x^8+x^6+x^5+x^4+1, free-running so the latched value depends on press timing.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lfsr_q  <= 8'h01;
            extra_q <= 3'd0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (state_q == SPIN && state_d == DECEL) extra_q <= lfsr_q[2:0];
        end
    end

    assign extra = extra_q;
`else
    assign extra = 3'd0;
`endif

    assign io.pos    = pos_q;
    assign io.hex    = ~{1'b0, pos_q};
    assign io.busy   = busy_q;
    assign io.done   = done_q;
    assign io.result = result_q;
    assign io.state  = state_q;

endmodule
